// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one bit per clock, LSB first, through a full
// subtractor; results latch once per operation when the last bit retires.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             brw;

    logic             x;
    logic             y;
    logic             hd;
    logic             d_bit;
    logic             b_next;
    logic [WIDTH-1:0] d_new;

    // Two half subtractors chained through the borrow flop.
    always_comb begin
        x      = a_sh[0];
        y      = b_sh[0];
        hd     = x ^ y;
        d_bit  = hd ^ brw;
        b_next = (~x & y) | (~hd & brw);
        d_new  = {d_bit, d_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            brw   <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            zero  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        d_sh  <= '0;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_new;
                    brw  <= b_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff  <= d_new;
                        bout  <= b_next;
                        zero  <= (d_new == '0);
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: stimulus pushes expected results,
// negedge monitors pop and compare whenever done is presented.
module tb_serial_sub_ctrl;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       z;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, bout, zero;
    logic [7:0] diff;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, bout4, zero4;
    logic [3:0] diff4;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t q4[$];

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", int'(diff), int'(e.d));
                chk("bout", int'(bout), int'(e.bo));
                chk("zero", int'(zero), int'(e.z));
                chk("latency_cycle", cyc, e.t);
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done4: got done=1 expected none (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("diff4", int'(diff4), int'(e.d[3:0]));
                chk("bout4", int'(bout4), int'(e.bo));
                chk("zero4", int'(zero4), int'(e.z));
                chk("latency_cycle4", cyc, e.t);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || busy4 || q.size() != 0 || q4.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(n >= 60), 0);
    endtask

    // Issue one operation from IDLE; optionally scramble a/b while in flight.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic eb, input logic ez,
                          input bit scramble);
        exp_t e;
        a = va;
        b = vb;
        start = 1'b1;
        e.d = ed; e.bo = eb; e.z = ez; e.t = cyc + 1 + 8;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            for (int i = 0; i < 8; i++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                @(negedge clk);
            end
        end
        wait_idle();
    endtask

    initial begin
        int base;
        int n;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_zero", int'(zero), 1);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_hold_diff", int'(diff), 8'h02);

        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op(8'hA7, 8'hA7, 8'h00, 1'b0, 1'b1, 1'b1);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Abort in the 4th RUN cycle.
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_zero", int'(zero), 1);
        repeat (12) @(negedge clk);
        chk("abort_no_done_pending", int'(busy), 0);

        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0);

        // Start held high: three back-to-back operations, 10 cycles apart.
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        base = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e.d = 8'hF0; e.bo = 1'b1; e.z = 1'b0; e.t = base + 8 + 10 * i;
            q.push_back(e);
        end
        repeat (22) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Stray start pulses in RUN and DONE must be ignored.
        a = 8'h5A;
        b = 8'h0F;
        start = 1'b1;
        e.d = 8'h4B; e.bo = 1'b0; e.z = 1'b0; e.t = cyc + 1 + 8;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stray_done_seen", int'(n < 20), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);
        chk("stray_idle", int'(busy), 0);

        // Narrow instance: 4-bit operands, 4-cycle latency.
        a4 = 4'h8;
        b4 = 4'h9;
        start4 = 1'b1;
        e.d = 8'h0F; e.bo = 1'b1; e.z = 1'b0; e.t = cyc + 1 + 4;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        wait_idle();

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size() + q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
